tdm_demux: RTL and testbench

Receive-side time-division demultiplexer: takes a serial bit stream with a frame-sync marker and distributes it into N_CH parallel W-bit channel words. It is the far end of the mux-based TDM serializer built from the team's 2:1 mux cells. A sync-driven FSM and counters re-frame the stream. Completed frames are presented in parallel with a one-cycle valid pulse.

---
 rtl/tdm_demux.sv | 129 ++++++++++++
 tb/tb_tdm_demux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Purpose  : Receive-side TDM demultiplexer. Re-frames a serial bit stream on
//            its sync marker and presents N_CH parallel W-bit channel words,
//            with one-cycle frame_valid / frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              din,
   input  logic              sync_in,
   output logic [N_CH*W-1:0] ch_out,
   output logic              frame_valid,
   output logic              frame_err
);

   localparam int c_BW = (W    > 1) ? $clog2(W)    : 1;
   localparam int c_CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(W - 1);
   localparam logic [c_CW-1:0] c_CH_LAST  = c_CW'(N_CH - 1);

   typedef enum logic [0:0] {
      S_HUNT = 1'b0,
      S_RECV = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_BW-1:0]     r_bit_cnt;
   logic [c_CW-1:0]     r_ch_cnt;
   // Only W-1 history bits are ever needed: the word leaves on the bit that
   // would otherwise fill the top position.
   logic [W-2:0]        r_sh;
   // The last channel is merged straight into ch_out, so no slot is kept for it.
   logic [(N_CH-1)*W-1:0] r_stg;

   logic [W-1:0]        w_word;
   logic                w_frame_start;
   logic                w_word_done;

   assign w_word        = {r_sh, din};
   assign w_frame_start = (r_bit_cnt == '0) && (r_ch_cnt == '0);
   assign w_word_done   = bit_en && (r_state == S_RECV) && !w_frame_start &&
                          !sync_in && (r_bit_cnt == c_BIT_LAST);

   // Staging slots for channels 0..N_CH-2, loaded as each word completes.
   for (genvar k = 0; k < N_CH - 1; k++) begin : g_stg
      // Capture the completed word into its slot.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stg[k*W +: W] <= '0;
         end else if (w_word_done && (r_ch_cnt == c_CW'(k))) begin
            r_stg[k*W +: W] <= w_word;
         end
      end
   end

   // Framing FSM, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_HUNT;
         r_bit_cnt   <= '0;
         r_ch_cnt    <= '0;
         r_sh        <= '0;
         ch_out      <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         if (bit_en) begin
            case (r_state)
               S_HUNT: begin
                  if (sync_in) begin
                     // Sync bit is the MSB of channel 0.
                     r_sh      <= '0;
                     r_sh[0]   <= din;
                     r_bit_cnt <= c_BW'(1);
                     r_ch_cnt  <= '0;
                     r_state   <= S_RECV;
                  end
               end
               S_RECV: begin
                  if (w_frame_start) begin
                     if (sync_in) begin
                        r_sh      <= '0;
                        r_sh[0]   <= din;
                        r_bit_cnt <= c_BW'(1);
                     end else begin
                        // Sync missing where a frame must begin: lose lock.
                        frame_err <= 1'b1;
                        r_state   <= S_HUNT;
                     end
                  end else if (sync_in) begin
                     // Early sync: drop the partial frame, re-align here.
                     frame_err <= 1'b1;
                     r_sh      <= '0;
                     r_sh[0]   <= din;
                     r_bit_cnt <= c_BW'(1);
                     r_ch_cnt  <= '0;
                  end else begin
                     r_sh <= w_word[W-2:0];
                     if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_ch_cnt == c_CH_LAST) begin
                           ch_out      <= {w_word, r_stg};
                           frame_valid <= 1'b1;
                           r_ch_cnt    <= '0;
                        end else begin
                           r_ch_cnt <= r_ch_cnt + c_CW'(1);
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + c_BW'(1);
                     end
                  end
               end
               default: r_state <= S_HUNT;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Purpose  : Directed self-checking bench for tdm_demux (N_CH=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

   logic        clk;
   logic        rst_n;
   logic        bit_en;
   logic        din;
   logic        sync_in;
   logic [31:0] ch_out;
   logic        frame_valid;
   logic        frame_err;

   int total;
   int bad;
   int edge_n;
   int n_valid;
   int n_err;
   int n_both;
   int valid_edge;
   int err_edge;
   int first_edge;
   int sync_edge;
   int v1;

   tdm_demux #(.N_CH(4), .W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_en      (bit_en),
      .din         (din),
      .sync_in     (sync_in),
      .ch_out      (ch_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, take the edge, then tally pulses 1ns later.
   task automatic step(input logic en, input logic s, input logic d);
      bit_en  = en;
      sync_in = s;
      din     = d;
      @(posedge clk);
      #1;
      if (frame_valid) begin
         n_valid++;
         valid_edge = edge_n;
      end
      if (frame_err) begin
         n_err++;
         err_edge = edge_n;
      end
      if (frame_valid && frame_err) n_both++;
   endtask

   // Send frame bits first..last (bit 0 = ch0 MSB); optional disabled gap cycle
   // after each enabled bit, with sync/din driven high to prove they are ignored.
   task automatic send_bits(input logic [31:0] word, input int first, input int last,
                            input logic sync_first, input logic gap);
      for (int i = first; i <= last; i++) begin
         step(1'b1, (i == first) && sync_first, word[(i/8)*8 + (7 - (i%8))]);
         if (i == first) first_edge = edge_n;
         if (gap) step(1'b0, 1'b1, 1'b1);
      end
   endtask

   task automatic clr;
      n_valid = 0;
      n_err   = 0;
   endtask

   initial begin
      total = 0; bad = 0; n_both = 0;
      n_valid = 0; n_err = 0; valid_edge = 0; err_edge = 0;
      first_edge = 0; sync_edge = 0; v1 = 0;
      rst_n = 1'b0; bit_en = 1'b0; sync_in = 1'b0; din = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ch_out", 64'(ch_out), 64'h0);
      chk("reset_valid", 64'(frame_valid), 64'h0);
      chk("reset_err", 64'(frame_err), 64'h0);
      rst_n = 1'b1;

      // Single frame, continuous bit_en.
      clr();
      send_bits(32'h01FF3CA5, 0, 31, 1'b1, 1'b0);
      sync_edge = first_edge;
      chk("single_ch_out", 64'(ch_out), 64'h01FF3CA5);
      chk("single_nvalid", 64'(n_valid), 64'd1);
      chk("single_latency", 64'(valid_edge - sync_edge), 64'd31);
      chk("single_nerr", 64'(n_err), 64'd0);

      // Back-to-back frames with bit_en toggling.
      clr();
      send_bits(32'h11223344, 0, 31, 1'b1, 1'b1);
      chk("b2b1_ch_out", 64'(ch_out), 64'h11223344);
      chk("b2b1_nvalid", 64'(n_valid), 64'd1);
      v1 = valid_edge;
      send_bits(32'hDEADBEEF, 0, 31, 1'b1, 1'b1);
      chk("b2b2_ch_out", 64'(ch_out), 64'hDEADBEEF);
      chk("b2b2_nvalid", 64'(n_valid), 64'd2);
      chk("b2b_spacing", 64'(valid_edge - v1), 64'd64);
      chk("b2b_nerr", 64'(n_err), 64'd0);

      // Early sync at bit 13 of a frame.
      clr();
      send_bits(32'hCAFEF00D, 0, 12, 1'b1, 1'b0);
      send_bits(32'h5A5A0FF0, 0, 0, 1'b1, 1'b0);
      sync_edge = first_edge;
      chk("early_nerr", 64'(n_err), 64'd1);
      chk("early_err_edge", 64'(err_edge), 64'(sync_edge));
      chk("early_ch_out_held", 64'(ch_out), 64'hDEADBEEF);
      chk("early_nvalid0", 64'(n_valid), 64'd0);
      send_bits(32'h5A5A0FF0, 1, 31, 1'b0, 1'b0);
      chk("early_ch_out_new", 64'(ch_out), 64'h5A5A0FF0);
      chk("early_nvalid1", 64'(n_valid), 64'd1);
      chk("early_latency", 64'(valid_edge - sync_edge), 64'd31);
      chk("early_nerr_after", 64'(n_err), 64'd1);

      // Missing sync at the frame boundary, then garbage while hunting.
      clr();
      step(1'b1, 1'b0, 1'b1);
      chk("miss_nerr", 64'(n_err), 64'd1);
      chk("miss_ch_out", 64'(ch_out), 64'h5A5A0FF0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
         if (i % 5 == 0) step(1'b0, 1'b1, 1'b1);
      end
      chk("hunt_nerr", 64'(n_err), 64'd1);
      chk("hunt_nvalid", 64'(n_valid), 64'd0);
      chk("hunt_ch_out", 64'(ch_out), 64'h5A5A0FF0);
      send_bits(32'h87654321, 0, 31, 1'b1, 1'b0);
      chk("resync_ch_out", 64'(ch_out), 64'h87654321);
      chk("resync_nvalid", 64'(n_valid), 64'd1);

      // Asynchronous reset mid-frame.
      send_bits(32'h13579BDF, 0, 9, 1'b1, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ch_out", 64'(ch_out), 64'h0);
      chk("async_rst_valid", 64'(frame_valid), 64'd0);
      chk("async_rst_err", 64'(frame_err), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clr();
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'(i % 3 == 0));
      chk("post_rst_ch_out", 64'(ch_out), 64'h0);
      chk("post_rst_nvalid", 64'(n_valid), 64'd0);
      chk("post_rst_nerr", 64'(n_err), 64'd0);
      send_bits(32'h2468ACE0, 0, 31, 1'b1, 1'b0);
      chk("post_rst_frame", 64'(ch_out), 64'h2468ACE0);
      chk("post_rst_nvalid1", 64'(n_valid), 64'd1);
      step(1'b1, 1'b1, 1'b0);
      chk("pulse_cleared", 64'(frame_valid), 64'd0);
      chk("never_both", 64'(n_both), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
